// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequences rs1/rs2 reads through a single registered
// register-file read port, retries reads blocked by writeback, and forwards.
module operand_fetch #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [TAG_W-1:0] dec_tag,
    output logic             rf_read_en,
    output logic [4:0]       rf_read_reg,
    input  logic [XLEN-1:0]  rf_read_data,
    input  logic             rf_write_en,
    input  logic [4:0]       rf_write_reg,
    input  logic [XLEN-1:0]  rf_write_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [TAG_W-1:0] ex_tag
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        CAP_A,
        ISSUE_B,
        CAP_B,
        VALID
    } state_t;

    state_t     state;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
    logic       need_b_q;

    logic need_a;
    logic need_b;
    logic fwd_a;
    logic fwd_b;

    assign dec_ready = (state == IDLE);
    assign need_a    = dec_use_rs1 && (dec_rs1 != '0);
    assign need_b    = dec_use_rs2 && (dec_rs2 != '0);

    // x0 is never fetched, but the guard keeps a snooped x0 write from forwarding.
    assign fwd_a = rf_write_en && (rf_write_reg == rs1_q) && (rs1_q != '0);
    assign fwd_b = rf_write_en && (rf_write_reg == rs2_q) && (rs2_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            need_b_q    <= 1'b0;
            rf_read_en  <= 1'b0;
            rf_read_reg <= '0;
            ex_valid    <= 1'b0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_tag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_valid) begin
                        rs1_q    <= dec_rs1;
                        rs2_q    <= dec_rs2;
                        need_b_q <= need_b;
                        ex_tag   <= dec_tag;
                        ex_op_a  <= '0;
                        ex_op_b  <= '0;
                        if (need_a) begin
                            state       <= ISSUE_A;
                            rf_read_en  <= 1'b1;
                            rf_read_reg <= dec_rs1;
                        end else if (need_b) begin
                            state       <= ISSUE_B;
                            rf_read_en  <= 1'b1;
                            rf_read_reg <= dec_rs2;
                        end else begin
                            state    <= VALID;
                            ex_valid <= 1'b1;
                        end
                    end
                end
                // A concurrent writeback wins the port; hold the request and retry.
                ISSUE_A: begin
                    if (!rf_write_en) begin
                        state      <= CAP_A;
                        rf_read_en <= 1'b0;
                    end
                end
                CAP_A: begin
                    ex_op_a <= fwd_a ? rf_write_data : rf_read_data;
                    if (need_b_q) begin
                        state       <= ISSUE_B;
                        rf_read_en  <= 1'b1;
                        rf_read_reg <= rs2_q;
                    end else begin
                        state    <= VALID;
                        ex_valid <= 1'b1;
                    end
                end
                ISSUE_B: begin
                    if (!rf_write_en) begin
                        state      <= CAP_B;
                        rf_read_en <= 1'b0;
                    end
                end
                CAP_B: begin
                    ex_op_b  <= fwd_b ? rf_write_data : rf_read_data;
                    state    <= VALID;
                    ex_valid <= 1'b1;
                end
                VALID: begin
                    if (ex_ready) begin
                        state    <= IDLE;
                        ex_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rf_read_en <= 1'b0;
                    ex_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
